// File: rtl/array_arbiter_pkg.sv
// array_arbiter_pkg: shared sizes, op encoding and FSM states for the array allocator
package array_arbiter_pkg;
  localparam int MemoryElementWidth = 12;
  localparam int NArrays = 200;
  typedef enum logic {OpAlloc = 1'b0, OpFree = 1'b1} opE;
  typedef enum logic [1:0] {Idle, Service, Grant} stateE;
  function automatic int idxWidth(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/array_arbiter_rr_select.sv
// rr_select: round-robin pick starting one past the previous winner
module rr_select #(
  parameter int NRequesters = 4,
  parameter int IdxW = 2
) (
  input  logic [NRequesters-1:0] req,
  input  logic [IdxW-1:0]        lastWinner,
  output logic [IdxW-1:0]        winner,
  output logic                   any
);
  always_comb begin
    int j;
    j = 0;
    winner = lastWinner;
    // walk offsets farthest-first so the nearest requester overwrites last
    for (int i = NRequesters; i >= 1; i--) begin
      j = int'(lastWinner) + i;
      if (j >= NRequesters) j -= NRequesters;
      if (req[IdxW'(j)]) winner = IdxW'(j);
    end
  end
  assign any = |req;
endmodule

// File: rtl/array_arbiter.sv
// array_arbiter: round-robin shared allocator of array numbers with a freed-number stack
module array_arbiter #(
  parameter int MemoryElementWidth = array_arbiter_pkg::MemoryElementWidth,
  parameter int NArrays = array_arbiter_pkg::NArrays,
  parameter int NRequesters = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NRequesters-1:0]                req,
  input  logic [NRequesters-1:0]                op,
  input  logic [NRequesters*MemoryElementWidth-1:0] freeArray,
  output logic [NRequesters-1:0]                grant,
  output logic [MemoryElementWidth-1:0]         arrayOut,
  output logic                                  error,
  output logic                                  clearSize,
  output logic [MemoryElementWidth-1:0]         inUse,
  output logic [MemoryElementWidth-1:0]         allocs
);
  import array_arbiter_pkg::*;
  localparam int W = MemoryElementWidth;
  localparam int IdxW = idxWidth(NRequesters);
  localparam int StackW = idxWidth(NArrays);
  typedef logic [W-1:0] elemT;
  localparam elemT Limit = elemT'(NArrays);
  stateE state, nextState;
  logic [IdxW-1:0] lastWinner, winner, pick;
  logic any, allocOk, freeOk, errFlag, clrFlag;
  opE curOp;
  elemT curFree, nextFresh, stackTop, result;
  elemT stack [NArrays];
  logic [StackW-1:0] topIdx, pushIdx;

  rr_select #(.NRequesters(NRequesters), .IdxW(IdxW)) uSelect (
    .req(req),
    .lastWinner(lastWinner),
    .winner(pick),
    .any(any)
  );

  assign allocOk = stackTop != '0 || nextFresh != Limit;
  assign freeOk = curFree < nextFresh && inUse != '0;
  assign topIdx = StackW'(stackTop - 1'b1);
  assign pushIdx = StackW'(stackTop);

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= Idle;
    else state <= nextState;

  always_comb nextState = state == Idle ? (any ? Service : Idle) : state == Service ? Grant : Idle;

  always_comb begin
    grant = '0;
    if (state == Grant) grant[winner] = 1'b1;
    error = state == Grant && errFlag;
    clearSize = state == Grant && clrFlag;
    arrayOut = state == Grant ? result : '0;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      lastWinner <= IdxW'(NRequesters - 1);
      winner <= '0;
      curOp <= OpAlloc;
      curFree <= '0;
      nextFresh <= '0;
      stackTop <= '0;
      inUse <= '0;
      allocs <= '0;
      result <= '0;
      errFlag <= 1'b0;
      clrFlag <= 1'b0;
    end else begin
      allocs <= inUse > allocs ? inUse : allocs;
      if (state == Idle && any) begin
        winner <= pick;
        curOp <= opE'(op[pick]);
        curFree <= freeArray[pick*W +: W];
      end
      if (state == Grant) lastWinner <= winner;
      if (state == Service && curOp == OpAlloc) begin
        errFlag <= !allocOk;
        clrFlag <= allocOk;
        result <= stackTop != '0 ? stack[topIdx] : allocOk ? nextFresh : '0;
        if (stackTop != '0) stackTop <= stackTop - 1'b1;
        else if (allocOk) nextFresh <= nextFresh + 1'b1;
        if (allocOk) inUse <= inUse + 1'b1;
      end
      if (state == Service && curOp == OpFree) begin
        errFlag <= !freeOk;
        clrFlag <= 1'b0;
        result <= curFree;
        if (freeOk) begin
          stackTop <= stackTop + 1'b1;
          inUse <= inUse - 1'b1;
        end
      end
    end

  always_ff @(posedge clock)
    if (state == Service && curOp == OpFree && freeOk) stack[pushIdx] <= curFree;
endmodule

// File: tb/tb_array_arbiter.sv
// tb_array_arbiter: directed table plus randomized rounds against a queue-based allocator model
module tb_array_arbiter;
  localparam int W = 12, NA = 4, NR = 4;
  logic clock = 1'b0, reset = 1'b0;
  logic [NR-1:0] req = '0, op = '0;
  logic [NR*W-1:0] freeArray = '0;
  logic [NR-1:0] grant;
  logic [W-1:0] arrayOut, inUse, allocs;
  logic error, clearSize;
  int vectors = 0, miscompares = 0;
  int mStack[$];
  int mNext = 0, mLast = NR - 1, mAllocs = 0;
  typedef struct {int who; bit o; int f; int eOut; bit eErr; bit eClr; int eInUse; int eAllocs;} vecT;
  vecT tbl[$];

  always #5 clock = ~clock;

  array_arbiter #(.MemoryElementWidth(W), .NArrays(NA), .NRequesters(NR)) dut (
    .clock(clock), .reset(reset), .req(req), .op(op), .freeArray(freeArray),
    .grant(grant), .arrayOut(arrayOut), .error(error), .clearSize(clearSize),
    .inUse(inUse), .allocs(allocs)
  );

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int modelInUse();
    return mNext - mStack.size();
  endfunction

  task automatic modelReset();
    mStack.delete();
    mNext = 0;
    mLast = NR - 1;
    mAllocs = 0;
  endtask

  // allocator semantics: LIFO reuse of freed numbers, then fresh numbers up to NA
  task automatic modelOp(input bit o, input int f, output int eOut, output bit eErr, output bit eClr);
    eClr = 1'b0;
    eErr = 1'b0;
    if (!o) begin
      if (mStack.size() > 0) begin eOut = mStack.pop_back(); eClr = 1'b1; end
      else if (mNext < NA) begin eOut = mNext; mNext++; eClr = 1'b1; end
      else begin eOut = 0; eErr = 1'b1; end
    end else begin
      eOut = f;
      if (f >= mNext || modelInUse() == 0) eErr = 1'b1;
      else mStack.push_back(f);
    end
    if (modelInUse() > mAllocs) mAllocs = modelInUse();
  endtask

  function automatic int modelWinner(input logic [NR-1:0] pend);
    for (int i = 1; i <= NR; i++) if (pend[(mLast + i) % NR]) return (mLast + i) % NR;
    return 0;
  endfunction

  task automatic doReset();
    req = '0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("reset grant", grant, 0);
    check("reset arrayOut", arrayOut, 0);
    check("reset error", error, 0);
    check("reset clearSize", clearSize, 0);
    check("reset inUse", inUse, 0);
    check("reset allocs", allocs, 0);
    reset = 1'b1;
    @(negedge clock);
    modelReset();
  endtask

  task automatic applyVec(input vecT v);
    int waits, eo;
    bit ee, ec;
    waits = 0;
    op[v.who] = v.o;
    freeArray[v.who*W +: W] = W'(v.f);
    req[v.who] = 1'b1;
    do begin @(negedge clock); waits++; end while (grant == '0 && waits < 8);
    check("vec latency", waits, 2);
    check("vec grant", grant, 1 << v.who);
    check("vec arrayOut", arrayOut, v.eOut);
    check("vec error", error, v.eErr);
    check("vec clearSize", clearSize, v.eClr);
    check("vec inUse", inUse, v.eInUse);
    req[v.who] = 1'b0;
    @(negedge clock);
    check("vec allocs", allocs, v.eAllocs);
    modelOp(v.o, v.f, eo, ee, ec);
    mLast = v.who;
  endtask

  task automatic runRound(input logic [NR-1:0] mask, input logic [NR-1:0] ops, input logic [NR*W-1:0] frees);
    logic [NR-1:0] pend;
    int waits, w, eo;
    bit ee, ec;
    pend = mask;
    op = ops;
    freeArray = frees;
    req = mask;
    while (pend != '0) begin
      waits = 0;
      do begin @(negedge clock); waits++; end while (grant == '0 && waits < 8);
      w = modelWinner(pend);
      modelOp(ops[w], int'(frees[w*W +: W]), eo, ee, ec);
      check("rr latency", waits, 2);
      check("rr grant", grant, 1 << w);
      check("rr arrayOut", arrayOut, eo);
      check("rr error", error, ee);
      check("rr clearSize", clearSize, ec);
      check("rr inUse", inUse, modelInUse());
      req = req & ~grant;
      req[w] = 1'b0;
      pend[w] = 1'b0;
      mLast = w;
      @(negedge clock);
      check("rr allocs", allocs, mAllocs);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    logic [NR*W-1:0] frees;
    tbl.push_back('{0, 1'b0, 0, 0, 1'b0, 1'b1, 1, 1});
    tbl.push_back('{1, 1'b0, 0, 1, 1'b0, 1'b1, 2, 2});
    tbl.push_back('{2, 1'b0, 0, 2, 1'b0, 1'b1, 3, 3});
    tbl.push_back('{3, 1'b1, 7, 7, 1'b1, 1'b0, 3, 3});
    tbl.push_back('{0, 1'b1, 1, 1, 1'b0, 1'b0, 2, 3});
    tbl.push_back('{1, 1'b0, 0, 1, 1'b0, 1'b1, 3, 3});
    tbl.push_back('{2, 1'b0, 0, 3, 1'b0, 1'b1, 4, 4});
    tbl.push_back('{3, 1'b0, 0, 0, 1'b1, 1'b0, 4, 4});
    tbl.push_back('{0, 1'b1, 0, 0, 1'b0, 1'b0, 3, 4});
    tbl.push_back('{1, 1'b1, 1, 1, 1'b0, 1'b0, 2, 4});
    tbl.push_back('{2, 1'b1, 2, 2, 1'b0, 1'b0, 1, 4});
    tbl.push_back('{3, 1'b1, 3, 3, 1'b0, 1'b0, 0, 4});
    tbl.push_back('{0, 1'b1, 2, 2, 1'b1, 1'b0, 0, 4});
    tbl.push_back('{1, 1'b0, 0, 3, 1'b0, 1'b1, 1, 4});
    doReset();
    foreach (tbl[i]) applyVec(tbl[i]);

    doReset();
    runRound(4'hF, 4'h0, '0);

    // reset lands while an allocate is in SERVICE
    doReset();
    op[0] = 1'b0;
    req[0] = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req = '0;
    @(negedge clock);
    check("abort inUse", inUse, 0);
    reset = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (grant != '0) seen = 1'b1;
    end
    check("abort no grant", seen, 0);
    modelReset();
    applyVec('{0, 1'b0, 0, 0, 1'b0, 1'b1, 1, 1});

    for (int r = 0; r < 150; r++) begin
      for (int k = 0; k < NR; k++) frees[k*W +: W] = W'($urandom_range(0, 5));
      runRound(NR'($urandom_range(1, 15)), NR'($urandom), frees);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/array_arbiter.md
ARRAY_ARBITER -- requirements
Module: array_arbiter

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, width of array numbers and counters.
REQ-002 SHALL have parameter NArrays, default 200, number of array numbers available.
REQ-003 SHALL have parameter NRequesters, default 4, number of requesters sharing the allocator.
REQ-004 SHALL have port clock  input  1  single clock; all state changes on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  NRequesters  per-requester request, held high until grant.
REQ-007 SHALL have port op  input  NRequesters  per-requester operation: 0 = allocate, 1 = free.
REQ-008 SHALL have port freeArray  input  NRequesters*MemoryElementWidth  array number to free, slice i for requester i.
REQ-009 SHALL have port grant  output  NRequesters  one-hot, one-cycle completion pulse.
REQ-010 SHALL have port arrayOut  output  MemoryElementWidth  allocated array number, valid while grant is high.
REQ-011 SHALL have port error  output  1  high with grant when the operation failed.
REQ-012 SHALL have port clearSize  output  1  one-cycle strobe: zero arraySizes[arrayOut].
REQ-013 SHALL have port inUse  output  MemoryElementWidth  arrays currently allocated.
REQ-014 SHALL have port allocs  output  MemoryElementWidth  high-water mark of inUse.

Function
REQ-015 SHALL run FSM IDLE -> SERVICE -> GRANT -> IDLE; IDLE holds while no req bit is high.
REQ-016 SHALL, in IDLE, pick the winner round-robin, searching from lastWinner+1 modulo NRequesters; latch index, op and freeArray slice.
REQ-017 SHALL, in SERVICE, perform the operation; in GRANT, drive grant[winner]=1 for exactly one cycle; grant is two edges after the sampling edge.
REQ-018 SHALL sustain at most one operation per three cycles; requesters drop req on the edge ending grant.
REQ-019 SHALL, for allocate, pop the freed-array stack when non-empty, else return nextFresh and increment it.
REQ-020 SHALL, for allocate with empty stack and nextFresh == NArrays, assert error, leave state unchanged, and drive arrayOut = 0.
REQ-021 SHALL pulse clearSize with grant on every successful allocate only.
REQ-022 SHALL, for free, push freeArray onto the stack (depth NArrays); arrayOut = freed number.
REQ-023 SHALL reject a free with error, without pushing, when freeArray >= nextFresh or inUse == 0.
REQ-024 SHALL maintain inUse = nextFresh - stackTop, updated in SERVICE.
REQ-025 SHALL update allocs to max(allocs, inUse) in the cycle after inUse changes; it never decreases except on reset.
REQ-026 SHALL advance lastWinner only on grant, including error grants.
REQ-027 SHALL ignore req changes during SERVICE/GRANT; a requester that drops req early still receives its grant.

Reset
REQ-028 SHALL, on reset low, asynchronously go to IDLE with grant=0, error=0, clearSize=0, arrayOut=0, inUse=0, allocs=0, nextFresh=0, stackTop=0, lastWinner=NRequesters-1.
REQ-029 SHALL abandon any in-flight operation on reset mid-operation; no grant follows it.

Structure
REQ-030 SHALL take MemoryElementWidth, NArrays, the op encoding and the FSM state enum from the shared zero package.
REQ-031 SHALL implement round-robin selection as sub-module rr_select (inputs req, lastWinner; outputs winner index, any).
REQ-032 SHALL hold the freed-array stack as a local register array, no memory macro.

Verification
REQ-033 Reset, then req[0] alloc -> grant[0] two edges after sampling, arrayOut=0, clearSize=1, inUse=1, allocs=1.
REQ-034 req[0..3] all alloc together -> grants in order 0,1,2,3, arrayOut 0,1,2,3, each 3 cycles apart.
REQ-035 Allocate 0,1,2; free 1; allocate -> arrayOut=1 from stack, inUse=3, allocs=3.
REQ-036 NArrays=4: allocate 4 times, fifth allocate -> error=1, arrayOut=0, clearSize=0, inUse=4.
REQ-037 Free 7 when nextFresh=3 -> error=1, stackTop unchanged; free with inUse=0 -> error=1.
REQ-038 Assert reset during SERVICE of an allocate -> no grant, inUse=0, next allocate returns 0.
